// File: rtl/conv_pkg.sv
// Shared types and width helpers for the convolution window engine.
package conv_pkg;

    // Kernel load state: nothing loaded, load in progress, full kernel present.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        LOAD  = 2'd1,
        READY = 2'd2
    } kstate_e;

    // Width of the full product sum; wide enough that no partial sum can overflow.
    function automatic int sum_width(input int dw, input int kw, input int taps);
        return dw + kw + $clog2(taps);
    endfunction

endpackage

// File: rtl/conv_adder_tree.sv
// Combinational pairwise adder tree. Leaves are extended to the output width
// (sign- or zero-extended), padded with zeros up to the next power of two,
// and reduced level by level.
module conv_adder_tree #(
    parameter int TAPS   = 9,
    parameter int IW     = 8,
    parameter int OW     = 12,
    parameter int SIGNED = 0
) (
    input  logic [TAPS*IW-1:0] terms,
    output logic [OW-1:0]      sum
);

    localparam int DEPTH  = $clog2(TAPS);
    localparam int LEAVES = 1 << DEPTH;

    genvar gl, gi;
    generate
        for (gl = 0; gl <= DEPTH; gl++) begin : g_lvl
            localparam int N = LEAVES >> gl;
            logic [OW-1:0] row [N];
            for (gi = 0; gi < N; gi++) begin : g_node
                if (gl == 0) begin : g_leaf
                    if (gi < TAPS) begin : g_term
                        if (SIGNED != 0) begin : g_sx
                            assign row[gi] = OW'($signed(terms[gi*IW +: IW]));
                        end else begin : g_zx
                            assign row[gi] = OW'(terms[gi*IW +: IW]);
                        end
                    end else begin : g_pad
                        assign row[gi] = '0;
                    end
                end else begin : g_add
                    assign row[gi] = g_lvl[gl-1].row[2*gi] + g_lvl[gl-1].row[2*gi+1];
                end
            end
        end
    endgenerate

    assign sum = g_lvl[DEPTH].row[0];

endmodule

// File: rtl/conv_window_engine.sv
// Three-stage K x K convolution engine: registered products, registered
// adder-tree sum, then round/shift/saturate into the output register.
// Serially loaded kernel with a small load FSM; valid/ready on both sides.
module conv_window_engine
    import conv_pkg::*;
#(
    parameter int TAPS   = 9,
    parameter int DW     = 4,
    parameter int KW     = 4,
    parameter int OUT_W  = 8,
    parameter int SHIFT  = 3,
    parameter int SIGNED = 0,
    parameter int ROUND  = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 k_start,
    input  logic                 k_wr_en,
    input  logic [KW-1:0]        k_wr_data,
    output logic                 kernel_ok,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [TAPS*DW-1:0]   in_win,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_W-1:0]     out_data,
    output logic                 out_sat
);

    localparam int PW = DW + KW;
    localparam int SW = sum_width(DW, KW, TAPS);
    // Two spare bits so the rounding add can never wrap the sign.
    localparam int RW = SW + 2;
    localparam int CW = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam logic [CW-1:0] LAST_TAP = CW'(TAPS - 1);

    localparam int SAT_MAX = (SIGNED != 0) ? (2**(OUT_W-1)) - 1 : (2**OUT_W) - 1;
    localparam int SAT_MIN = (SIGNED != 0) ? -(2**(OUT_W-1)) : 0;
    localparam logic signed [RW-1:0] SAT_MAX_V = RW'(SAT_MAX);
    localparam logic signed [RW-1:0] SAT_MIN_V = RW'(SAT_MIN);
    // Half an LSB of the shifted result; zero when SHIFT is 0 or rounding is off.
    localparam logic signed [RW-1:0] RND_V = (ROUND != 0) ? RW'((2**SHIFT) / 2) : '0;

    kstate_e         state_reg, state_next;
    logic [CW-1:0]   cnt_reg, cnt_next;
    logic            kern_we;
    logic [KW-1:0]   kern_reg [TAPS];

    logic                advance, accept;
    logic                v1_reg, v2_reg, out_valid_reg;
    logic [TAPS*PW-1:0]  prod_w, prod_reg;
    logic [SW-1:0]       tree_sum, sum_reg;
    logic [OUT_W-1:0]    out_data_reg, sat_data;
    logic                out_sat_reg, sat_flag;
    logic signed [RW-1:0] sum_ext, rnd_sum, shifted;

    // Kernel FSM state and tap counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= EMPTY;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Next-state: k_start wins over a same-cycle write; writes only count in LOAD.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        kern_we    = 1'b0;
        if (k_start) begin
            state_next = LOAD;
            cnt_next   = '0;
        end else if (state_reg == LOAD && k_wr_en) begin
            kern_we = 1'b1;
            if (cnt_reg == LAST_TAP) begin
                state_next = READY;
                cnt_next   = '0;
            end else begin
                cnt_next = cnt_reg + CW'(1);
            end
        end
    end

    // Coefficient registers, written in tap order during a load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < TAPS; i++) kern_reg[i] <= '0;
        end else begin
            for (int i = 0; i < TAPS; i++) begin
                if (kern_we && cnt_reg == CW'(i)) kern_reg[i] <= k_wr_data;
            end
        end
    end

    assign kernel_ok = (state_reg == READY);
    assign advance   = !out_valid_reg || out_ready;
    assign in_ready  = advance && kernel_ok;
    assign accept    = in_valid && in_ready;

    // Per-tap multipliers; operands extended to the product width first.
    genvar gi;
    generate
        for (gi = 0; gi < TAPS; gi++) begin : g_mul
            logic [PW-1:0] pix_ext, coef_ext;
            if (SIGNED != 0) begin : g_s
                assign pix_ext  = PW'($signed(in_win[gi*DW +: DW]));
                assign coef_ext = PW'($signed(kern_reg[gi]));
            end else begin : g_u
                assign pix_ext  = PW'(in_win[gi*DW +: DW]);
                assign coef_ext = PW'(kern_reg[gi]);
            end
            assign prod_w[gi*PW +: PW] = pix_ext * coef_ext;
        end
    endgenerate

    conv_adder_tree #(
        .TAPS   (TAPS),
        .IW     (PW),
        .OW     (SW),
        .SIGNED (SIGNED)
    ) u_tree (
        .terms (prod_reg),
        .sum   (tree_sum)
    );

    // Round, shift and clip the registered sum.
    always_comb begin
        if (SIGNED != 0) sum_ext = RW'($signed(sum_reg));
        else             sum_ext = RW'({1'b0, sum_reg});
        rnd_sum  = sum_ext + RND_V;
        shifted  = rnd_sum >>> SHIFT;
        sat_flag = 1'b0;
        sat_data = shifted[OUT_W-1:0];
        if (shifted > SAT_MAX_V) begin
            sat_flag = 1'b1;
            sat_data = SAT_MAX_V[OUT_W-1:0];
        end else if (shifted < SAT_MIN_V) begin
            sat_flag = 1'b1;
            sat_data = SAT_MIN_V[OUT_W-1:0];
        end
    end

    // Pipeline: every stage moves on advance; data only loads behind a valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_reg        <= 1'b0;
            v2_reg        <= 1'b0;
            out_valid_reg <= 1'b0;
            prod_reg      <= '0;
            sum_reg       <= '0;
            out_data_reg  <= '0;
            out_sat_reg   <= 1'b0;
        end else if (advance) begin
            v1_reg        <= accept;
            v2_reg        <= v1_reg;
            out_valid_reg <= v2_reg;
            if (accept) prod_reg <= prod_w;
            if (v1_reg) sum_reg  <= tree_sum;
            if (v2_reg) begin
                out_data_reg <= sat_data;
                out_sat_reg  <= sat_flag;
            end
        end
    end

    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign out_sat   = out_sat_reg;

endmodule

// File: tb/tb_conv_window_engine.sv
// Bench for conv_window_engine: four instances (default, SHIFT=0, ROUND=0,
// SIGNED=1) share one stimulus; directed table plus handshake/reload sequences.
module tb_conv_window_engine;

    localparam int TAPS = 9;
    localparam int DW   = 4;
    localparam int KW   = 4;
    localparam int OW   = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic               k_start, k_wr_en, in_valid, out_ready;
    logic [KW-1:0]      k_wr_data;
    logic [TAPS*DW-1:0] in_win;

    logic d_kernel_ok, d_in_ready, d_out_valid, d_out_sat;
    logic z_kernel_ok, z_in_ready, z_out_valid, z_out_sat;
    logic n_kernel_ok, n_in_ready, n_out_valid, n_out_sat;
    logic g_kernel_ok, g_in_ready, g_out_valid, g_out_sat;
    logic [OW-1:0] d_out_data, z_out_data, n_out_data, g_out_data;

    conv_window_engine u_def (
        .clk(clk), .rst_n(rst_n), .k_start(k_start), .k_wr_en(k_wr_en), .k_wr_data(k_wr_data),
        .kernel_ok(d_kernel_ok), .in_valid(in_valid), .in_ready(d_in_ready), .in_win(in_win),
        .out_valid(d_out_valid), .out_ready(out_ready), .out_data(d_out_data), .out_sat(d_out_sat));

    conv_window_engine #(.SHIFT(0)) u_s0 (
        .clk(clk), .rst_n(rst_n), .k_start(k_start), .k_wr_en(k_wr_en), .k_wr_data(k_wr_data),
        .kernel_ok(z_kernel_ok), .in_valid(in_valid), .in_ready(z_in_ready), .in_win(in_win),
        .out_valid(z_out_valid), .out_ready(out_ready), .out_data(z_out_data), .out_sat(z_out_sat));

    conv_window_engine #(.ROUND(0)) u_nr (
        .clk(clk), .rst_n(rst_n), .k_start(k_start), .k_wr_en(k_wr_en), .k_wr_data(k_wr_data),
        .kernel_ok(n_kernel_ok), .in_valid(in_valid), .in_ready(n_in_ready), .in_win(in_win),
        .out_valid(n_out_valid), .out_ready(out_ready), .out_data(n_out_data), .out_sat(n_out_sat));

    conv_window_engine #(.SIGNED(1)) u_sg (
        .clk(clk), .rst_n(rst_n), .k_start(k_start), .k_wr_en(k_wr_en), .k_wr_data(k_wr_data),
        .kernel_ok(g_kernel_ok), .in_valid(in_valid), .in_ready(g_in_ready), .in_win(in_win),
        .out_valid(g_out_valid), .out_ready(out_ready), .out_data(g_out_data), .out_sat(g_out_sat));

    typedef struct {
        logic [35:0] kern;
        logic [35:0] win;
        logic [7:0]  e_def;
        logic        s_def;
        logic [7:0]  e_s0;
        logic        s_s0;
        logic [7:0]  e_nr;
        logic [7:0]  e_sg;
        logic        s_sg;
    } vec_t;

    vec_t vecs [10];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [35:0] uni(input logic [3:0] v);
        return {9{v}};
    endfunction

    function automatic logic [35:0] win_for(input int n);
        logic [3:0] t0, t1;
        t0 = (n < 16) ? 4'(n) : 4'hF;
        t1 = (n < 16) ? 4'h0 : 4'(n - 15);
        return {28'h0, t1, t0};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_kernel(input logic [35:0] k);
        k_start = 1'b1;
        step();
        k_start = 1'b0;
        for (int i = 0; i < TAPS; i++) begin
            k_wr_en   = 1'b1;
            k_wr_data = k[i*KW +: KW];
            step();
        end
        k_wr_en = 1'b0;
    endtask

    // Offer one window, then wait (bounded) for the result; lat = cycles to out_valid.
    task automatic apply_win(input logic [35:0] w, output int lat);
        in_win   = w;
        in_valid = 1'b1;
        @(negedge clk);
        chk("accept_ready", d_in_ready, 1);
        step();
        in_valid = 1'b0;
        lat = 0;
        while (lat < 10) begin
            @(negedge clk);
            lat++;
            if (d_out_valid) break;
        end
    endtask

    // Stream monitor on the SHIFT=0 instance, whose output equals the raw sum.
    logic       mon_en = 1'b0;
    int         exp_q[$];
    int         rcv = 0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data = '0;

    always @(negedge clk) begin
        if (mon_en && z_out_valid) begin
            if (prev_stall) chk("stall_hold", z_out_data, prev_data);
            if (out_ready) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL stream_extra: got %0d expected no result", z_out_data);
                end else begin
                    chk("stream_data", z_out_data, exp_q.pop_front());
                end
                rcv++;
            end
            prev_stall <= !out_ready;
            prev_data  <= z_out_data;
        end else begin
            prev_stall <= 1'b0;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat, sent, cyc, base, seen;

        vecs[0] = '{uni(4'h1), uni(4'h1),     8'd1,   1'b0, 8'd9,   1'b0, 8'd1,   8'd1,   1'b0};
        vecs[1] = '{uni(4'hF), uni(4'hF),     8'd253, 1'b0, 8'd255, 1'b1, 8'd253, 8'd1,   1'b0};
        vecs[2] = '{uni(4'h1), 36'h000000444, 8'd2,   1'b0, 8'd12,  1'b0, 8'd1,   8'd2,   1'b0};
        vecs[3] = '{uni(4'h7), uni(4'h8),     8'd63,  1'b0, 8'd255, 1'b1, 8'd63,  8'hC1,  1'b0};
        vecs[4] = '{uni(4'hF), uni(4'h7),     8'd118, 1'b0, 8'd255, 1'b1, 8'd118, 8'hF8,  1'b0};
        vecs[5] = '{uni(4'h8), uni(4'h8),     8'd72,  1'b0, 8'd255, 1'b1, 8'd72,  8'd72,  1'b0};
        vecs[6] = '{uni(4'h2), 36'h876543210, 8'd9,   1'b0, 8'd72,  1'b0, 8'd9,   8'd5,   1'b0};
        vecs[7] = '{uni(4'h3), 36'h000000000, 8'd0,   1'b0, 8'd0,   1'b0, 8'd0,   8'd0,   1'b0};
        vecs[8] = '{uni(4'h1), 36'h000000004, 8'd1,   1'b0, 8'd4,   1'b0, 8'd0,   8'd1,   1'b0};
        vecs[9] = '{36'h000000005, 36'h711111116, 8'd4, 1'b0, 8'd30, 1'b0, 8'd3,  8'd4,   1'b0};

        k_start = 0; k_wr_en = 0; k_wr_data = '0; in_valid = 0; in_win = '0; out_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", d_out_valid, 0);
        chk("rst_out_data",  d_out_data,  0);
        chk("rst_out_sat",   d_out_sat,   0);
        chk("rst_kernel_ok", d_kernel_ok, 0);
        chk("rst_in_ready",  d_in_ready,  0);
        step();
        rst_n = 1'b1;

        // Writes in EMPTY are ignored
        k_wr_en = 1'b1; k_wr_data = 4'hF;
        repeat (TAPS + 1) step();
        k_wr_en = 1'b0;
        @(negedge clk);
        chk("empty_wr_ok", d_kernel_ok, 0);

        // Write in the k_start cycle is dropped: nine further writes are needed
        step();
        k_start = 1'b1; k_wr_en = 1'b1; k_wr_data = 4'hF;
        step();
        k_start = 1'b0; k_wr_data = 4'h1;
        repeat (TAPS - 1) step();
        k_wr_en = 1'b0;
        @(negedge clk);
        chk("drop_wr_ok8", d_kernel_ok, 0);
        step();
        k_wr_en = 1'b1;
        step();
        k_wr_en = 1'b0;
        @(negedge clk);
        chk("drop_wr_ok9", d_kernel_ok, 1);
        step();
        apply_win(uni(4'h1), lat);
        chk("drop_wr_data", d_out_data, 1);

        // Directed vector table
        for (int i = 0; i < 10; i++) begin
            step();
            load_kernel(vecs[i].kern);
            k_wr_en = 1'b1; k_wr_data = 4'hF;   // stray write while READY
            step();
            k_wr_en = 1'b0;
            apply_win(vecs[i].win, lat);
            chk($sformatf("v%0d_latency", i), lat, 3);
            chk($sformatf("v%0d_def", i),     d_out_data, vecs[i].e_def);
            chk($sformatf("v%0d_def_sat", i), d_out_sat,  vecs[i].s_def);
            chk($sformatf("v%0d_s0", i),      z_out_data, vecs[i].e_s0);
            chk($sformatf("v%0d_s0_sat", i),  z_out_sat,  vecs[i].s_s0);
            chk($sformatf("v%0d_nr", i),      n_out_data, vecs[i].e_nr);
            chk($sformatf("v%0d_sg", i),      g_out_data, vecs[i].e_sg);
            chk($sformatf("v%0d_sg_sat", i),  g_out_sat,  vecs[i].s_sg);
        end

        // Asynchronous reset mid-flight discards window and kernel
        step();
        load_kernel(uni(4'h1));
        in_win = uni(4'h1); in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1 chk("async_rst_ok", d_kernel_ok, 0);
        step();
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (d_out_valid) seen = 1;
        end
        chk("rst_flush", seen, 0);
        chk("rst_ready", d_in_ready, 0);

        // 20-window stream with out_ready toggling every 2 cycles
        step();
        load_kernel(uni(4'h1));
        mon_en = 1'b1;
        sent = 0; cyc = 0; base = rcv;
        while ((sent < 20 || rcv < base + 20) && cyc < 400) begin
            out_ready = cyc[1];
            if (sent < 20) begin
                in_valid = 1'b1;
                in_win   = win_for(sent);
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (in_valid && d_in_ready) begin
                exp_q.push_back(sent);
                sent++;
            end
            step();
            cyc++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        chk("stream_count", rcv - base, 20);

        // Reload mid-stream: k_start with the 3rd accept, then kernel of 2s
        step();
        base = rcv;
        in_win = uni(4'h1);
        for (int j = 0; j < 3; j++) begin
            in_valid = 1'b1;
            k_start  = (j == 2);
            @(negedge clk);
            chk("reload_acc_old", d_in_ready, 1);
            if (d_in_ready) exp_q.push_back(9);
            step();
        end
        k_start = 1'b0; k_wr_en = 1'b1; k_wr_data = 4'h2;
        for (int j = 0; j < TAPS; j++) begin
            @(negedge clk);
            chk("reload_blocked", d_in_ready, 0);
            step();
        end
        k_wr_en = 1'b0;
        for (int j = 0; j < 2; j++) begin
            @(negedge clk);
            chk("reload_acc_new", d_in_ready, 1);
            if (d_in_ready) exp_q.push_back(18);
            step();
        end
        in_valid = 1'b0;
        cyc = 0;
        while (rcv < base + 5 && cyc < 20) begin
            step();
            cyc++;
        end
        chk("reload_count", rcv - base, 5);
        mon_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
